// File: rtl/avalon_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_tester_pkg
// Description : Shared types and helpers for the Avalon BlockRAM self-test
//               host: FSM state encoding, the pattern multiplier, and the
//               word-pattern generator used for both the write and
//               compare paths.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_tester_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BEAT = 3'd1,
        RD_CMD  = 3'd2,
        RD_DATA = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [31:0] PAT_MULT = 32'h0101_0101;

    // Word i of the test image: seed XOR (i * 0x01010101), truncated to 32 bits.
    function automatic logic [31:0] pattern(input logic [31:0] seed,
                                            input logic [31:0] idx);
        return seed ^ (idx * PAT_MULT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_burst_ctr.sv
`default_nettype none
// ============================================================================
// Module      : avalon_burst_ctr
// Description : Per-burst beat down-counter shared by the write and read
//               phases, plus the burst length min(MAXB, remaining).
// Ports       : clk, reset_n   - clock, async active-low reset
//               load           - start a new burst of burst_len beats
//               dec            - one beat of the current burst completed
//               remaining      - words left from the next burst's start
//               burst_len      - min(MAXB, remaining)
//               last_beat      - current beat is the final one of the burst
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_burst_ctr #(
    parameter int IDX_W        = 7,
    parameter int BURSTCOUNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    dec,
    input  logic [IDX_W-1:0]        remaining,
    output logic [BURSTCOUNT_W-1:0] burst_len,
    output logic                    last_beat
);

    localparam int c_max_burst = 2 ** (BURSTCOUNT_W - 1);

    logic [BURSTCOUNT_W-1:0] r_beats;

    always_comb begin
        if (32'(remaining) >= 32'(c_max_burst)) begin
            burst_len = BURSTCOUNT_W'(c_max_burst);
        end else begin
            burst_len = BURSTCOUNT_W'(remaining);
        end
    end

    // Load wins over decrement: the last beat of one burst and the issue of
    // the next happen on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beats <= '0;
        end else if (load) begin
            r_beats <= burst_len;
        end else if (dec && (r_beats != '0)) begin
            r_beats <= r_beats - BURSTCOUNT_W'(1);
        end
    end

    assign last_beat = (r_beats == BURSTCOUNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/avalon_bram_tester.sv
`default_nettype none
// ============================================================================
// Module      : avalon_bram_tester
// Description : Burst-capable Avalon-MM host that fills the whole target RAM
//               with a deterministic pattern, reads it back burst by burst,
//               and reports pass/fail, mismatch count and first bad address.
// Ports       : clk, reset_n          - clock, async active-low reset
//               start                 - one-cycle pulse, accepted only idle
//               busy/done/pass        - test status
//               error_count           - saturating mismatch count
//               first_err_addr        - byte address of first mismatch
//               proto_err             - sticky stray-readdatavalid flag
//               avm_*                 - Avalon-MM host interface
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_bram_tester
    import avalon_tester_pkg::*;
#(
    parameter int          RAM_ADD_W    = 8,
    parameter int          BURSTCOUNT_W = 4,
    parameter int          DATA_W       = 32,
    parameter logic [31:0] SEED         = 32'h0000_0001
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             error_count,
    output logic [31:0]             first_err_addr,
    output logic                    proto_err,
    output logic [31:0]             avm_address,
    output logic [BURSTCOUNT_W-1:0] avm_burstcount,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [DATA_W-1:0]       avm_writedata,
    input  logic [DATA_W-1:0]       avm_readdata,
    input  logic                    avm_readdatavalid,
    input  logic                    avm_waitrequest
);

    localparam int                 c_num_words = 2 ** (RAM_ADD_W - 2);
    // One extra bit so the index can express N itself (remaining count).
    localparam int                 c_idx_w     = RAM_ADD_W - 1;
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(c_num_words - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_idx_w-1:0]      w_idx_inc;
    logic [c_idx_w-1:0]      w_base;
    logic [c_idx_w-1:0]      w_remaining;
    logic [31:0]             w_issue_addr;
    logic [31:0]             w_exp_rd;
    logic [BURSTCOUNT_W-1:0] w_burst_len;
    logic                    w_last_beat;
    logic                    w_last_word;
    logic                    w_start_ok;
    logic                    w_wr_acc;
    logic                    w_rd_beat;
    logic                    w_stray;
    logic                    w_mismatch;
    logic                    w_load;
    logic                    w_dec;

    avalon_burst_ctr #(
        .IDX_W        (c_idx_w),
        .BURSTCOUNT_W (BURSTCOUNT_W)
    ) u_burst_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_load),
        .dec       (w_dec),
        .remaining (w_remaining),
        .burst_len (w_burst_len),
        .last_beat (w_last_beat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_inc    = r_idx + c_idx_w'(1);
        w_last_word  = (r_idx == c_last_idx);
        w_start_ok   = (r_state == IDLE) && start;
        w_wr_acc     = (r_state == WR_BEAT) && avm_write && !avm_waitrequest;
        w_rd_beat    = (r_state == RD_DATA) && avm_readdatavalid;
        // Any beat outside RD_DATA has no outstanding burst to belong to.
        w_stray      = avm_readdatavalid && (r_state != RD_DATA);
        w_exp_rd     = pattern(SEED, 32'(r_idx));
        w_mismatch   = w_rd_beat && (avm_readdata != w_exp_rd);

        case (r_state)
            IDLE:    if (start) w_state_next = WR_BEAT;
            WR_BEAT: if (w_wr_acc && w_last_beat && w_last_word) w_state_next = RD_CMD;
            RD_CMD:  if (!avm_waitrequest) w_state_next = RD_DATA;
            RD_DATA: if (w_rd_beat && w_last_beat) w_state_next = w_last_word ? DONE : RD_CMD;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        // A new burst is issued on start, at every write burst boundary and
        // after every read burst except the last one.
        w_load = w_start_ok
              || (w_wr_acc && w_last_beat)
              || (w_rd_beat && w_last_beat && !w_last_word);
        w_dec  = w_wr_acc || w_rd_beat;

        // First word of the burst being issued: 0 for the first write burst
        // and the first read burst, otherwise the word after the current one.
        w_base       = ((r_state == IDLE) || ((r_state == WR_BEAT) && w_last_word))
                     ? '0 : w_idx_inc;
        w_remaining  = c_idx_w'(c_num_words) - w_base;
        w_issue_addr = 32'(w_base) << 2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            proto_err      <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            if (w_stray) begin
                proto_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        error_count    <= '0;
                        first_err_addr <= '0;
                        proto_err      <= 1'b0;
                        r_idx          <= '0;
                        avm_write      <= 1'b1;
                        avm_address    <= w_issue_addr;
                        avm_burstcount <= w_burst_len;
                        avm_writedata  <= pattern(SEED, 32'd0);
                    end
                end

                WR_BEAT: begin
                    if (w_wr_acc) begin
                        if (w_last_beat && w_last_word) begin
                            avm_write      <= 1'b0;
                            avm_read       <= 1'b1;
                            avm_address    <= w_issue_addr;
                            avm_burstcount <= w_burst_len;
                            r_idx          <= '0;
                        end else begin
                            r_idx         <= w_idx_inc;
                            avm_writedata <= pattern(SEED, 32'(w_idx_inc));
                            if (w_last_beat) begin
                                avm_address    <= w_issue_addr;
                                avm_burstcount <= w_burst_len;
                            end
                        end
                    end
                end

                RD_CMD: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                    end
                end

                RD_DATA: begin
                    if (w_rd_beat) begin
                        if (w_mismatch) begin
                            if (error_count != 16'hFFFF) begin
                                error_count <= error_count + 16'd1;
                            end
                            // The count only leaves zero on the first miss.
                            if (error_count == '0) begin
                                first_err_addr <= 32'(r_idx) << 2;
                            end
                        end
                        if (!w_last_word) begin
                            r_idx <= w_idx_inc;
                        end
                        if (w_last_beat && !w_last_word) begin
                            avm_read       <= 1'b1;
                            avm_address    <= w_issue_addr;
                            avm_burstcount <= w_burst_len;
                        end
                    end
                end

                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (error_count == '0) && !proto_err;
                end

                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_bram_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_bram_tester
// Description : Directed self-checking bench for avalon_bram_tester with a
//               behavioural Avalon RAM agent per DUT and a write/read-command
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_bram_tester;

    localparam int          N    = 64;
    localparam int          MAXB = 8;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;

    // Default-parameter DUT
    logic        start = 1'b0;
    logic        busy, done, pass, proto_err;
    logic [15:0] error_count;
    logic [31:0] first_err_addr, avm_address, avm_writedata;
    logic [3:0]  avm_burstcount;
    logic        avm_read, avm_write;
    logic [31:0] avm_readdata      = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest   = 1'b0;

    // Small DUT: N=8, MAXB=4
    logic        s_start = 1'b0;
    logic        s_busy, s_done, s_pass, s_proto_err;
    logic [15:0] s_error_count;
    logic [31:0] s_first_err_addr, s_avm_address, s_avm_writedata;
    logic [2:0]  s_avm_burstcount;
    logic        s_avm_read, s_avm_write;
    logic [31:0] s_avm_readdata      = '0;
    logic        s_avm_readdatavalid = 1'b0;
    logic        s_avm_waitrequest   = 1'b0;

    avalon_bram_tester dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .error_count(error_count), .first_err_addr(first_err_addr),
        .proto_err(proto_err), .avm_address(avm_address),
        .avm_burstcount(avm_burstcount), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
    );

    avalon_bram_tester #(.RAM_ADD_W(5), .BURSTCOUNT_W(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(s_start), .busy(s_busy), .done(s_done),
        .pass(s_pass), .error_count(s_error_count), .first_err_addr(s_first_err_addr),
        .proto_err(s_proto_err), .avm_address(s_avm_address),
        .avm_burstcount(s_avm_burstcount), .avm_read(s_avm_read), .avm_write(s_avm_write),
        .avm_writedata(s_avm_writedata), .avm_readdata(s_avm_readdata),
        .avm_readdatavalid(s_avm_readdatavalid), .avm_waitrequest(s_avm_waitrequest)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return SEED ^ (32'(i) * 32'h0101_0101);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] baddr;
        logic [31:0] data;
        logic [3:0]  bc;
    } wr_exp_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  bc;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    task automatic load_scoreboard();
        wr_q.delete();
        rd_q.delete();
        for (int i = 0; i < N; i++)
            wr_q.push_back('{baddr: 32'((i / MAXB) * MAXB * 4), data: pat(i), bc: 4'(MAXB)});
        for (int b = 0; b < N / MAXB; b++)
            rd_q.push_back('{addr: 32'(b * MAXB * 4), bc: 4'(MAXB)});
    endtask

    // ---------------- agent for the default DUT ----------------
    logic [31:0] mem [0:N-1];
    logic        corrupt [0:N-1];
    int stall_word = -1, stall_len = 0, inj_req = 0, run_no = 0;
    logic [31:0] stall_baddr = '0;
    int seen_run = 0, inj_done = 0, wbeat = 0, wr_beats = 0, rd_cmds = 0;
    int rd_word = 0, rd_left = 0, rd_delay = 0, stall_used = 0, w_word;
    wr_exp_t we;
    rd_exp_t re;

    always @(negedge clk) begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        if (!reset_n || run_no != seen_run) begin
            seen_run = run_no; wbeat = 0; wr_beats = 0; rd_cmds = 0;
            rd_left = 0; rd_delay = 0; stall_used = 0;
        end else begin
            if (avm_write) begin
                w_word = int'(avm_address >> 2) + wbeat;
                if (w_word == stall_word && stall_used < stall_len) begin
                    avm_waitrequest = 1'b1;
                    stall_used++;
                    check("stall_hold_addr", avm_address, stall_baddr);
                    check("stall_hold_data", avm_writedata, pat(stall_word));
                    check("stall_hold_bc", 32'(avm_burstcount), 32'(MAXB));
                end else begin
                    if (w_word < N) mem[w_word] = avm_writedata;
                    check("wr_q_nonempty", 32'(wr_q.size() != 0), 32'd1);
                    if (wr_q.size() != 0) begin
                        we = wr_q.pop_front();
                        check("wr_addr", avm_address, we.baddr);
                        check("wr_data", avm_writedata, we.data);
                        check("wr_bc", 32'(avm_burstcount), 32'(we.bc));
                    end
                    wbeat++;
                    if (wbeat >= int'(avm_burstcount)) wbeat = 0;
                    wr_beats++;
                end
            end
            if (avm_read) begin
                check("rd_q_nonempty", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    re = rd_q.pop_front();
                    check("rd_addr", avm_address, re.addr);
                    check("rd_bc", 32'(avm_burstcount), 32'(re.bc));
                end
                rd_word  = int'(avm_address >> 2);
                rd_left  = int'(avm_burstcount);
                rd_delay = 1;
                rd_cmds++;
            end else if (rd_left > 0) begin
                if (rd_delay > 0) begin
                    rd_delay--;
                end else begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem[rd_word] ^ {31'b0, corrupt[rd_word]};
                    rd_word++;
                    rd_left--;
                end
            end
            if (inj_req != inj_done && !avm_readdatavalid) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hDEAD_BEEF;
                inj_done          = inj_req;
            end
        end
    end

    // ---------------- agent for the small DUT ----------------
    logic [31:0] s_mem [0:7];
    int   s_wr_beats = 0, s_rd_cmds = 0, s_rd_word = 0, s_rd_left = 0, s_rd_delay = 0;
    int   s_done_rises = 0;
    logic s_done_d = 1'b0;

    always @(negedge clk) begin
        s_avm_waitrequest   = 1'b0;
        s_avm_readdatavalid = 1'b0;
        if (!reset_n) begin
            s_wr_beats = 0; s_rd_cmds = 0; s_rd_left = 0; s_rd_delay = 0;
            s_done_rises = 0; s_done_d = 1'b0;
        end else begin
            if (s_done && !s_done_d) s_done_rises++;
            s_done_d = s_done;
            if (s_avm_write) begin
                check("s_wr_addr", s_avm_address, 32'((s_wr_beats / 4) * 16));
                check("s_wr_data", s_avm_writedata, pat(s_wr_beats));
                check("s_wr_bc", 32'(s_avm_burstcount), 32'd4);
                if (s_wr_beats < 8) s_mem[s_wr_beats] = s_avm_writedata;
                s_wr_beats++;
            end
            if (s_avm_read) begin
                check("s_rd_addr", s_avm_address, 32'(s_rd_cmds * 16));
                check("s_rd_bc", 32'(s_avm_burstcount), 32'd4);
                s_rd_word  = int'(s_avm_address >> 2);
                s_rd_left  = int'(s_avm_burstcount);
                s_rd_delay = 1;
                s_rd_cmds++;
            end else if (s_rd_left > 0) begin
                if (s_rd_delay > 0) begin
                    s_rd_delay--;
                end else begin
                    s_avm_readdatavalid = 1'b1;
                    s_avm_readdata      = s_mem[s_rd_word];
                    s_rd_word++;
                    s_rd_left--;
                end
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic start_run();
        load_scoreboard();
        run_no++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(done === 1'b1), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic exp_pass,
                                input logic [15:0] exp_ec, input logic [31:0] exp_fea,
                                input logic exp_proto);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        check({tag, "_err_cnt"}, 32'(error_count), 32'(exp_ec));
        check({tag, "_first_err"}, first_err_addr, exp_fea);
        check({tag, "_proto"}, 32'(proto_err), 32'(exp_proto));
        check({tag, "_wr_beats"}, 32'(wr_beats), 32'(N));
        check({tag, "_rd_cmds"}, 32'(rd_cmds), 32'(N / MAXB));
        check({tag, "_wr_q_left"}, 32'(wr_q.size()), 32'd0);
        check({tag, "_rd_q_left"}, 32'(rd_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err_cnt"}, 32'(error_count), 32'd0);
        check({tag, "_first_err"}, first_err_addr, 32'd0);
        check({tag, "_proto"}, 32'(proto_err), 32'd0);
        check({tag, "_addr"}, avm_address, 32'd0);
        check({tag, "_bc"}, 32'(avm_burstcount), 32'd0);
        check({tag, "_read"}, 32'(avm_read), 32'd0);
        check({tag, "_write"}, 32'(avm_write), 32'd0);
        check({tag, "_wdata"}, avm_writedata, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int k;
        for (int i = 0; i < N; i++) corrupt[i] = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_s_busy", 32'(s_busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: zero-wait agent
        start_run();
        check("r1_first_write", 32'(avm_write), 32'd1);
        check("r1_first_addr", avm_address, 32'd0);
        check("r1_first_bc", 32'(avm_burstcount), 32'(MAXB));
        check("r1_first_wdata", avm_writedata, pat(0));
        check("r1_busy", 32'(busy), 32'd1);
        wait_done("r1", cyc);
        // N writes + 8 x (cmd + 1 latency + 8 beats) + DONE, seen one cycle later
        check("r1_cycles", 32'(cyc), 32'(N + (N / MAXB) * (2 + MAXB) + 2));
        check_result("r1", 1'b1, 16'd0, 32'd0, 1'b0);

        // Run 2: 3-cycle stall on beat 5 of burst 2 (word 12)
        stall_word  = MAXB + 4;
        stall_len   = 3;
        stall_baddr = 32'(MAXB * 4);
        start_run();
        wait_done("r2", cyc);
        check("r2_cycles", 32'(cyc), 32'(N + (N / MAXB) * (2 + MAXB) + 2 + 3));
        check("r2_stall_cycles", 32'(stall_used), 32'd3);
        check_result("r2", 1'b1, 16'd0, 32'd0, 1'b0);
        stall_word = -1;
        stall_len  = 0;

        // Run 3: corrupted words 10 and 40
        corrupt[10] = 1'b1;
        corrupt[40] = 1'b1;
        start_run();
        wait_done("r3", cyc);
        check_result("r3", 1'b0, 16'd2, 32'h28, 1'b0);
        corrupt[10] = 1'b0;
        corrupt[40] = 1'b0;

        // Run 4: stray readdatavalid during the write phase
        start_run();
        k = 0;
        while (wr_beats < 20 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("r4_reach_wr20", 32'(wr_beats >= 20), 32'd1);
        inj_req++;
        wait_done("r4", cyc);
        check_result("r4", 1'b0, 16'd0, 32'd0, 1'b1);

        // Run 5: reset during read burst 4, then a clean rerun
        start_run();
        k = 0;
        while (rd_cmds < 4 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("r5_reach_rd4", 32'(rd_cmds >= 4), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("r5_pre_rst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("r5_mid_rst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_run();
        wait_done("r5b", cyc);
        check_result("r5b", 1'b1, 16'd0, 32'd0, 1'b0);

        // Small DUT: second start while busy must be ignored
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("s_busy_after_start", 32'(s_busy), 32'd1);
        repeat (3) @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        k = 0;
        while (s_done !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("s_done_seen", 32'(s_done === 1'b1), 32'd1);
        repeat (20) @(negedge clk);
        check("s_done_level", 32'(s_done), 32'd1);
        check("s_busy_end", 32'(s_busy), 32'd0);
        check("s_pass", 32'(s_pass), 32'd1);
        check("s_err_cnt", 32'(s_error_count), 32'd0);
        check("s_proto", 32'(s_proto_err), 32'd0);
        check("s_wr_beats", 32'(s_wr_beats), 32'd8);
        check("s_rd_cmds", 32'(s_rd_cmds), 32'd2);
        check("s_done_rises", 32'(s_done_rises), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avalon_bram_tester.md
Name: avalon_bram_tester

Overview:
- Avalon-MM host (burst-capable) sitting directly upstream of the team's Avalon BlockRAM agent.
- On a start pulse it fills the whole RAM with a deterministic pattern using burst writes, reads everything back with burst reads, and compares.
- It reports done, pass/fail, error count and first failing address.
- Serves as the bring-up / self-test driver for the RAM controller on board and in simulation.

Parameters:
- RAM_ADD_W, 8, byte-address width of the target RAM; word count N = 2**(RAM_ADD_W-2).
- BURSTCOUNT_W, 4, burstcount width; max burst length MAXB = 2**(BURSTCOUNT_W-1).
- DATA_W, 32, Avalon data width; fixed at 32 for byte-lane addressing.
- SEED, 32'h0000_0001, pattern seed.

Ports:
- clk  in  1  single clock for everything.
- reset_n  in  1  asynchronous assert, active-low reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- busy  out  1  high from accepted start until done.
- done  out  1  level, set at end of test, cleared by the next accepted start.
- pass  out  1  valid when done: error_count==0 and no protocol error.
- error_count  out  16  mismatching words, saturating at 16'hFFFF.
- first_err_addr  out  32  byte address of first mismatch; 0 if none.
- proto_err  out  1  sticky: readdatavalid seen while no read burst is outstanding.
- avm_address  out  32  byte address, word aligned (bits[1:0]=0).
- avm_burstcount  out  BURSTCOUNT_W  burst length.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read beat valid.
- avm_waitrequest  in  1  agent stall.

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0 (address, burstcount, read, write, writedata, busy, done, pass, error_count, first_err_addr, proto_err).
- Pattern: pat(i) = SEED ^ (i * 32'h0101_0101), with i the word index 0..N-1, truncated to 32 bits. Byte address = i<<2.
- Burst length = min(MAXB, N - i_burst_start); with defaults N=64, MAXB=8, giving 8 bursts of 8.
- States:
  - IDLE: on start go to WR_BEAT. Set busy=1, done=0; clear counters and proto_err.
  - WR_BEAT:
    - avm_write=1; address and burstcount valid and stable for the whole burst.
    - avm_writedata = pat(i) for the current beat.
    - A beat is accepted when write && !waitrequest; then i++ and data advances next cycle.
    - While waitrequest is high, all host outputs are held.
    - After the last beat of the last burst: deassert write and go to RD_CMD. Otherwise start the next burst immediately, with no idle cycle required.
  - RD_CMD:
    - avm_read=1 with address/burstcount, held until !waitrequest.
    - Then deassert read and go to RD_DATA with beat counter = burstcount.
  - RD_DATA:
    - Each readdatavalid beat is compared to pat(j), then j++.
    - On mismatch: error_count++ (saturating). If first mismatch, latch first_err_addr = j<<2.
    - When the beat counter reaches 0: go to RD_CMD for the next burst, or DONE when j==N.
    - Exactly one read burst outstanding at a time.
  - DONE: one cycle; set done=1, busy=0, pass=(error_count==0 && !proto_err); go to IDLE.
- Latency: first avm_write high the cycle after start is sampled. Total time with a zero-wait agent = N write cycles + per read burst (1 command cycle + agent read latency + beats) + 1.
- Boundaries:
  - readdatavalid in IDLE/WR_BEAT/RD_CMD sets proto_err; the data is not compared.
  - readdatavalid in the same cycle as the last expected beat: only the expected beat counts.
  - start while busy is ignored.
  - start in the same cycle DONE completes is ignored.
  - reset_n low mid-burst: outputs drop asynchronously; the test is abandoned.
  - Counters never wrap past N; error_count saturates.
  - waitrequest high indefinitely: the block stalls (no timeout).

Decomposition:
- Package avalon_tester_pkg:
  - state enum (IDLE, WR_BEAT, RD_CMD, RD_DATA, DONE);
  - PAT_MULT constant 32'h0101_0101;
  - function pattern(seed, idx).
- Sub-module avalon_burst_ctr: per-burst beat down-counter plus burstcount = min(MAXB, remaining) computation, shared by the write and read paths.

Test Plan:
- Zero-wait agent, defaults, start pulse -> 64 write beats (8 bursts, burstcount=8, addresses 0x00, 0x20 … 0xE0), 8 read bursts. Final state: done=1, pass=1, error_count=0.
- Agent inserts waitrequest=1 for 3 cycles on beat 5 of burst 2 -> address, writedata and write held stable; same final result as the stall-free run.
- Agent corrupts word 10 (readdata ^ 1) and word 40 -> error_count=2, first_err_addr=0x28, pass=0.
- Spurious readdatavalid injected during the write phase -> proto_err=1, pass=0, error_count=0.
- reset_n pulsed low during read burst 4, then start again -> all outputs 0 immediately on reset; second run completes with pass=1.
- RAM_ADD_W=5, BURSTCOUNT_W=3 (N=8, MAXB=4); start asserted again while busy -> two bursts of 4 each way; the extra start is ignored; a single done.
